vedic_mac_accum: RTL and testbench
==================================

# vedic_mac_accum

Accumulation stage placed directly downstream of the 4x4 Vedic multiplier `tt_um_vedic_4x4`. It consumes a stream of 8-bit products over a valid/ready handshake and sums a programmed number of them into an accumulator. It then presents the sum, with an overflow flag, on a held output handshake. This turns the combinational multiplier into a sequential multiply-accumulate / dot-product path.

## Interface
- `ACC_W`, default 10: accumulator and result width in bits; must be ≥ 8.
- `CNT_W`, default 4: width of the run-length field; at most 2^CNT_W−1 products per run.

Ports, clock and reset first:
- `clk`  in  1  — the single clock; all state changes on its rising edge.
- `rst_n`  in  1  — reset; asynchronous and active-low.
- `start`  in  1  — begin a run; sampled only in IDLE.
- `len`  in  CNT_W  — number of products in the run; latched when `start` is accepted.
- `p`  in  8  — product from the multiplier.
- `p_valid`  in  1  — `p` is valid this cycle.
- `p_ready`  out  1  — block accepts `p` this cycle.
- `res`  out  ACC_W  — accumulated result.
- `res_valid`  out  1  — `res` and `ovf` are valid.
- `res_ready`  in  1  — consumer accepts `res`.
- `ovf`  out  1  — overflow occurred during the run; sticky for the run.
- `busy`  out  1  — high whenever the state is not IDLE.

## Operation
- The state machine has three states: IDLE, ACCUM and DONE.
- **IDLE:**
  - `start`=1 with `len`≠0 → ACCUM. On that edge: acc←0, ovf←0, remaining←`len`.
  - `start`=1 with `len`=0 → DONE. On that edge: res←0, ovf←0.
  - Otherwise stay in IDLE.
- **ACCUM:**
  - `p_ready`=1.
  - A transfer occurs on any cycle with `p_valid & p_ready`. On a transfer, acc ← acc + zero-extended `p`, and remaining decrements.
  - The transfer with remaining=1 moves the state to DONE. On that same edge, `res` is loaded with the final sum.
  - Cycles with `p_valid`=0 are stalls; no state changes.
- **DONE:**
  - `res_valid`=1, and `res`/`ovf` are held stable.
  - `res_ready`=1 → IDLE.
  - Otherwise stay in DONE indefinitely.
- `start` is ignored outside IDLE, including in the cycle where DONE is left. A new run therefore begins no earlier than the cycle after leaving DONE.
- Arithmetic rules:
  - The addition is performed at ACC_W+1 bits.
  - Bit ACC_W set means overflow: `ovf`←1 and stays 1 until the next accepted `start`.
  - The stored value depends on `VEDIC_MAC_SAT_EN` (see Configuration).
- Outputs are decoded from registered state only. `p_ready` = (state==ACCUM) and has no combinational path from `p_valid`.
- `p` is ignored whenever `p_ready`=0.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state IDLE
  - `p_ready`=0, `res_valid`=0, `res`=0, `ovf`=0, `busy`=0
  - internal acc=0, remaining=0
- Reset mid-run: the partial sum is discarded. After release, the block idles until a new `start`.
- `start` accepted at edge N → `p_ready`=1 from cycle N+1.
- Last product accepted at edge M → `res_valid`=1 from cycle M+1.
- Minimum run latency, from `start` to `res_valid`, is `len`+1 cycles with `p_valid` held high.
- `len`=0: `res_valid`=1 in the cycle after `start`, with `res`=0 and `ovf`=0.
- `res_valid` falls in the cycle after the edge where `res_ready`=1 is sampled.

## Configuration
- Macro: `VEDIC_MAC_SAT_EN`.
- Defined: saturating accumulation. On overflow, acc clamps to 2^ACC_W−1 and stays clamped for the rest of the run. `ovf`=1.
- Undefined: wrapping accumulation. acc is taken modulo 2^ACC_W. `ovf`=1 on any carry out.

## Test plan
- **Basic sum:** `len`=3; products 10, 20, 30 with `p_valid` held high → `res`=60, `ovf`=0; `res_valid` rises the cycle after the third transfer.
- **Zero length:** `len`=0 with `start` → next cycle `res_valid`=1, `res`=0, `ovf`=0; `p_ready` never asserts.
- **Overflow:** `len`=5, all products 255 (total 1275).
  - Wrap build: `res`=251, `ovf`=1.
  - `VEDIC_MAC_SAT_EN` build: `res`=1023, `ovf`=1.
- **Stalls and backpressure:** `len`=4; products 1, 2, 3, 4 with 2-cycle `p_valid` gaps → `res`=10. Hold `res_ready`=0 for 5 cycles → `res`/`res_valid` stable. `start` pulses during DONE are ignored.
- **Reset mid-run:** `len`=6; after 3 products, assert `rst_n`=0 → all outputs 0 immediately. After release, a `len`=2 run of 7 and 8 → `res`=15.
- **Back-to-back runs:** `res_ready` held high; runs of 100+100 then 5+6 → `res`=200 then 11; `ovf` cleared between runs.

Source files
------------

// File: rtl/vedic_mac_accum_if.sv
// ============================================================================
//  Module   : vedic_mac_accum_if
//  Purpose  : Product-in / result-out handshake bundle for vedic_mac_accum.
//             master = stimulus / multiplier side, slave = accumulator.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface vedic_mac_accum_if #(
    parameter int ACC_W = 10,
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic [7:0]       p;
    logic             p_valid;
    logic             p_ready;
    logic [ACC_W-1:0] res;
    logic             res_valid;
    logic             res_ready;
    logic             ovf;
    logic             busy;

    modport master (
        output start, len, p, p_valid, res_ready,
        input  p_ready, res, res_valid, ovf, busy
    );

    modport slave (
        input  start, len, p, p_valid, res_ready,
        output p_ready, res, res_valid, ovf, busy
    );
endinterface

`default_nettype wire

// File: rtl/vedic_mac_accum.sv
// ============================================================================
//  Module   : vedic_mac_accum
//  Purpose  : Sums a programmed number of 8-bit products from the Vedic 4x4
//             multiplier and presents the total with a sticky overflow flag
//             on a held result handshake.
//  Options  : VEDIC_MAC_SAT_EN defined -> saturating accumulation,
//             undefined -> wrapping accumulation (default).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vedic_mac_accum #(
    parameter int ACC_W = 10,
    parameter int CNT_W = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    vedic_mac_accum_if.slave  bus
);
    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_ACCUM   = 2'd1;
    localparam logic [1:0]       c_DONE    = 2'd2;
    localparam logic [ACC_W-1:0] c_ACC_MAX = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_rem;
    logic [ACC_W-1:0] r_res;
    logic             r_ovf;

    logic             w_xfer;
    logic             w_last;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_p_ready;
    logic             w_res_valid;
    logic             w_busy;

    // One extra bit on the adder captures the carry used as the overflow flag.
    assign w_xfer  = (r_state == c_ACCUM) && bus.p_valid;
    assign w_last  = w_xfer && (r_rem == CNT_W'(1));
    assign w_sum   = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, bus.p};
    assign w_carry = w_sum[ACC_W];

`ifdef VEDIC_MAC_SAT_EN
    // Once clamped at the maximum, any further add carries again, so the
    // value stays pinned for the rest of the run.
    assign w_acc_nxt = w_carry ? c_ACC_MAX : w_sum[ACC_W-1:0];
`else
    assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; start is only looked at while idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_state_nxt = (bus.len != '0) ? c_ACCUM : c_DONE;
            c_ACCUM: if (w_last)    w_state_nxt = c_DONE;
            c_DONE:  if (bus.res_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the registered state.
    always_comb begin
        w_p_ready   = 1'b0;
        w_res_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            c_ACCUM: begin
                w_p_ready = 1'b1;
                w_busy    = 1'b1;
            end
            c_DONE: begin
                w_res_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulator, run-length counter, result and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_rem <= '0;
            r_res <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                        r_rem <= bus.len;
                        if (bus.len == '0) r_res <= '0;
                    end
                end
                c_ACCUM: begin
                    if (w_xfer) begin
                        r_acc <= w_acc_nxt;
                        r_rem <= r_rem - CNT_W'(1);
                        r_ovf <= r_ovf | w_carry;
                        if (w_last) r_res <= w_acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.p_ready   = w_p_ready;
    assign bus.res_valid = w_res_valid;
    assign bus.busy      = w_busy;
    assign bus.res       = r_res;
    assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_vedic_mac_accum.sv
// ============================================================================
//  Module   : tb_vedic_mac_accum
//  Purpose  : Self-checking bench for vedic_mac_accum: directed runs from the
//             test plan plus randomized runs against a sum-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vedic_mac_accum;
    localparam int     ACC_W     = 10;
    localparam int     CNT_W     = 4;
    localparam longint c_ACC_MAX = (64'd1 << ACC_W) - 1;

    logic clk;
    logic rst_n;

    vedic_mac_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_if ();

    vedic_mac_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_err = 0;
    int     n_chk = 0;
    int     gap_lo = 0;
    int     gap_hi = 0;
    longint prods[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected result from the plain arithmetic total of the run.
    task automatic model(output longint er, output longint eo);
        longint s = 0;
        foreach (prods[i]) s += prods[i];
        eo = (s > c_ACC_MAX) ? 1 : 0;
`ifdef VEDIC_MAC_SAT_EN
        er = (s > c_ACC_MAX) ? c_ACC_MAX : s;
`else
        er = s % (c_ACC_MAX + 1);
`endif
    endtask

    // One full run using the products in prods; bp = DONE backpressure cycles.
    task automatic run(input int bp, input bit held);
        int     n = prods.size();
        longint er, eo;
        model(er, eo);
        u_if.res_ready = held;
        u_if.len       = CNT_W'(n);
        u_if.start     = 1'b1;
        step();
        u_if.start = 1'b0;
        check("busy_after_start", u_if.busy, 1);
        if (n != 0) begin
            check("p_ready_on", u_if.p_ready, 1);
            check("ovf_cleared", u_if.ovf, 0);
            for (int k = 0; k < n; k++) begin
                int gaps = $urandom_range(gap_hi, gap_lo);
                for (int g = 0; g < gaps; g++) begin
                    u_if.p_valid = 1'b0;
                    u_if.p       = 8'($urandom);
                    step();
                    check("stall_p_ready", u_if.p_ready, 1);
                    check("stall_no_res", u_if.res_valid, 0);
                end
                check("pre_xfer_no_res", u_if.res_valid, 0);
                u_if.p_valid = 1'b1;
                u_if.p       = 8'(prods[k]);
                step();
            end
            u_if.p_valid = 1'b0;
            u_if.p       = 8'($urandom);
        end
        check("res_valid", u_if.res_valid, 1);
        check("res", u_if.res, er);
        check("ovf", u_if.ovf, eo);
        check("p_ready_done", u_if.p_ready, 0);
        for (int b = 0; b < bp; b++) begin
            u_if.start = 1'($urandom_range(1, 0));
            u_if.len   = CNT_W'($urandom);
            step();
            check("hold_valid", u_if.res_valid, 1);
            check("hold_res", u_if.res, er);
            check("hold_ovf", u_if.ovf, eo);
        end
        // start in the leaving cycle must be ignored.
        u_if.res_ready = 1'b1;
        u_if.start     = 1'b1;
        u_if.len       = CNT_W'(3);
        step();
        u_if.start     = 1'b0;
        u_if.res_ready = held;
        check("valid_dropped", u_if.res_valid, 0);
        check("idle_busy", u_if.busy, 0);
        check("idle_p_ready", u_if.p_ready, 0);
    endtask

    initial begin
        u_if.start     = 1'b0;
        u_if.len       = '0;
        u_if.p         = '0;
        u_if.p_valid   = 1'b0;
        u_if.res_ready = 1'b0;
        rst_n          = 1'b0;
        repeat (3) step();
        check("rst_p_ready", u_if.p_ready, 0);
        check("rst_res_valid", u_if.res_valid, 0);
        check("rst_res", u_if.res, 0);
        check("rst_ovf", u_if.ovf, 0);
        check("rst_busy", u_if.busy, 0);
        rst_n = 1'b1;
        step();

        // Basic sum
        prods = '{10, 20, 30};
        run(0, 1'b0);
        // Zero length
        prods.delete();
        run(1, 1'b0);
        // Overflow
        prods = '{255, 255, 255, 255, 255};
        run(0, 1'b0);
        // Stalls and backpressure
        gap_lo = 2; gap_hi = 2;
        prods = '{1, 2, 3, 4};
        run(5, 1'b0);
        gap_lo = 0; gap_hi = 0;

        // Reset mid-run
        u_if.len   = CNT_W'(6);
        u_if.start = 1'b1;
        step();
        u_if.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            u_if.p_valid = 1'b1;
            u_if.p       = 8'(50 + k);
            step();
        end
        u_if.p_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_p_ready", u_if.p_ready, 0);
        check("mid_rst_res_valid", u_if.res_valid, 0);
        check("mid_rst_res", u_if.res, 0);
        check("mid_rst_ovf", u_if.ovf, 0);
        check("mid_rst_busy", u_if.busy, 0);
        step();
        rst_n = 1'b1;
        u_if.p_valid = 1'b1;
        u_if.p       = 8'd99;
        step();
        u_if.p_valid = 1'b0;
        check("post_rst_idle", u_if.busy, 0);
        prods = '{7, 8};
        run(0, 1'b0);

        // Back-to-back runs with res_ready held high
        prods = '{100, 100};
        run(0, 1'b1);
        prods = '{5, 6};
        run(0, 1'b1);
        u_if.res_ready = 1'b0;

        // Randomized runs
        gap_lo = 2; gap_hi = 0;
        for (int r = 0; r < 30; r++) begin
            int n = $urandom_range(15, 0);
            prods.delete();
            for (int k = 0; k < n; k++) prods.push_back(longint'($urandom_range(255, 0)));
            if ((r % 4) == 3) run(0, 1'b1);
            else              run($urandom_range(4, 0), 1'b0);
            u_if.res_ready = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
